// File: rtl/alu_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_ctrl_if
// Purpose  : Decode-to-execute bundle carrying ALU class, instruction, flags
// Revision : 1.0
// ============================================================================
interface alu_ctrl_if;
    logic [1:0]  ALUOp;
    logic [31:0] instruction;
    logic        zero;
    logic        lt;
    logic        ltu;
    logic        branch_taken;
    logic [3:0]  ALUCtrl;

    modport master (
        output ALUOp, instruction, zero, lt, ltu,
        input  branch_taken, ALUCtrl
    );

    modport slave (
        input  ALUOp, instruction, zero, lt, ltu,
        output branch_taken, ALUCtrl
    );
endinterface
`default_nettype wire

// File: rtl/alu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_ctrl
// Purpose  : ALU operation decode and branch resolution, registered outputs
// Revision : 1.0
// ============================================================================
module alu_ctrl (
    input  wire          clk,
    input  wire          rst,
    alu_ctrl_if.slave    bus
);
    localparam logic [3:0] c_ADD    = 4'b0000;
    localparam logic [3:0] c_SUB    = 4'b0001;
    localparam logic [3:0] c_AND    = 4'b0010;
    localparam logic [3:0] c_OR     = 4'b0011;
    localparam logic [3:0] c_XOR    = 4'b0100;
    localparam logic [3:0] c_SLL    = 4'b0101;
    localparam logic [3:0] c_SRL    = 4'b0110;
    localparam logic [3:0] c_SRA    = 4'b0111;
    localparam logic [3:0] c_SLT    = 4'b1000;
    localparam logic [3:0] c_SLTU   = 4'b1001;
    localparam logic [3:0] c_MUL    = 4'b1010;
    localparam logic [3:0] c_MULH   = 4'b1011;
    localparam logic [3:0] c_MULHSU = 4'b1100;
    localparam logic [3:0] c_MULHU  = 4'b1101;

    localparam logic [6:0] c_F7_BASE = 7'b0000000;
    localparam logic [6:0] c_F7_ALT  = 7'b0100000;
    localparam logic [6:0] c_F7_MEXT = 7'b0000001;

    logic [2:0] w_funct3;
    logic [6:0] w_funct7;
    logic       w_is_rtype;
    logic       w_unused_bits;
    logic [3:0] ctrl_d,  ctrl_q;
    logic       taken_d, taken_q;

    assign w_funct3      = bus.instruction[14:12];
    assign w_funct7      = bus.instruction[31:25];
    assign w_is_rtype    = bus.instruction[5];
    assign w_unused_bits = ^{bus.instruction[24:15], bus.instruction[11:6],
                             bus.instruction[4:0]};

    always_comb begin
        ctrl_d  = c_ADD;
        taken_d = 1'b0;
        case (bus.ALUOp)
            2'b01: begin
                ctrl_d = c_SUB;
                case (w_funct3)
                    3'b000:  taken_d = bus.zero;
                    3'b001:  taken_d = ~bus.zero;
                    3'b100:  taken_d = bus.lt;
                    3'b101:  taken_d = ~bus.lt;
                    3'b110:  taken_d = bus.ltu;
                    3'b111:  taken_d = ~bus.ltu;
                    default: taken_d = 1'b0;
                endcase
            end
            2'b10: begin
                if (w_is_rtype) begin
                    case (w_funct7)
                        c_F7_BASE: begin
                            case (w_funct3)
                                3'b000:  ctrl_d = c_ADD;
                                3'b001:  ctrl_d = c_SLL;
                                3'b010:  ctrl_d = c_SLT;
                                3'b011:  ctrl_d = c_SLTU;
                                3'b100:  ctrl_d = c_XOR;
                                3'b101:  ctrl_d = c_SRL;
                                3'b110:  ctrl_d = c_OR;
                                default: ctrl_d = c_AND;
                            endcase
                        end
                        c_F7_ALT: begin
                            if (w_funct3 == 3'b000)      ctrl_d = c_SUB;
                            else if (w_funct3 == 3'b101) ctrl_d = c_SRA;
                        end
                        c_F7_MEXT: begin
                            // div/rem (funct3 1xx) have no ALU code and fall back to ADD
                            case (w_funct3)
                                3'b000:  ctrl_d = c_MUL;
                                3'b001:  ctrl_d = c_MULH;
                                3'b010:  ctrl_d = c_MULHSU;
                                3'b011:  ctrl_d = c_MULHU;
                                default: ctrl_d = c_ADD;
                            endcase
                        end
                        default: ctrl_d = c_ADD;
                    endcase
                end else begin
                    case (w_funct3)
                        3'b000: ctrl_d = c_ADD;
                        3'b001: ctrl_d = (w_funct7 == c_F7_BASE) ? c_SLL : c_ADD;
                        3'b010: ctrl_d = c_SLT;
                        3'b011: ctrl_d = c_SLTU;
                        3'b100: ctrl_d = c_XOR;
                        3'b101: begin
                            if (w_funct7 == c_F7_BASE)     ctrl_d = c_SRL;
                            else if (w_funct7 == c_F7_ALT) ctrl_d = c_SRA;
                        end
                        3'b110:  ctrl_d = c_OR;
                        default: ctrl_d = c_AND;
                    endcase
                end
            end
            default: begin
                ctrl_d  = c_ADD;
                taken_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q  <= c_ADD;
            taken_q <= 1'b0;
        end else begin
            ctrl_q  <= ctrl_d;
            taken_q <= taken_d;
        end
    end

    assign bus.ALUCtrl      = ctrl_q;
    assign bus.branch_taken = taken_q;
endmodule
`default_nettype wire

// File: tb/tb_alu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_ctrl
// Purpose  : Self-checking bench for alu_ctrl (directed rows plus random)
// Revision : 1.0
// ============================================================================
module tb_alu_ctrl;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    alu_ctrl_if bus ();

    alu_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference decode written from the operation table, by mnemonic lookups.
    function automatic void model(input logic [1:0] op, input logic [31:0] ins,
                                  input logic z, input logic l, input logic lu,
                                  output logic [3:0] ctrl, output logic taken);
        logic [3:0] r_base [8];
        logic [3:0] i_base [8];
        logic [7:0] conds;
        logic [2:0] f3;
        logic [6:0] f7;
        r_base = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd4, 4'd6, 4'd3, 4'd2};
        i_base = '{4'd0, 4'd0, 4'd8, 4'd9, 4'd4, 4'd0, 4'd3, 4'd2};
        f3 = ins[14:12];
        f7 = ins[31:25];
        conds = {~lu, lu, ~l, l, 1'b0, 1'b0, ~z, z};
        ctrl  = 4'd0;
        taken = 1'b0;
        if (op == 2'b01) begin
            ctrl  = 4'd1;
            taken = conds[f3];
        end else if (op == 2'b10 && ins[5]) begin
            if (f7 == 7'd0)
                ctrl = r_base[f3];
            else if (f7 == 7'h20 && f3 == 3'd0)
                ctrl = 4'd1;
            else if (f7 == 7'h20 && f3 == 3'd5)
                ctrl = 4'd7;
            else if (f7 == 7'h01 && f3 < 3'd4)
                ctrl = 4'd10 + {1'b0, f3};
        end else if (op == 2'b10) begin
            ctrl = i_base[f3];
            if (f3 == 3'd1 && f7 == 7'd0) ctrl = 4'd5;
            if (f3 == 3'd5 && f7 == 7'd0) ctrl = 4'd6;
            if (f3 == 3'd5 && f7 == 7'h20) ctrl = 4'd7;
        end
    endfunction

    task automatic drive(input logic [1:0] op, input logic [31:0] ins,
                         input logic z, input logic l, input logic lu);
        bus.ALUOp       = op;
        bus.instruction = ins;
        bus.zero        = z;
        bus.lt          = l;
        bus.ltu         = lu;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(2'b10, 32'h40000033, 1'b0, 1'b0, 1'b0);
        #2;
        n_checks++;
        if ({bus.ALUCtrl, bus.branch_taken} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_immediate: got %b/%b want 0000/0", bus.ALUCtrl, bus.branch_taken);
        end
        tick();
        n_checks++;
        if ({bus.ALUCtrl, bus.branch_taken} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_held: got %b/%b want 0000/0", bus.ALUCtrl, bus.branch_taken);
        end
        rst = 1'b0;
        tick();
        n_checks++;
        if (bus.ALUCtrl !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_release: got %b want 0001", bus.ALUCtrl);
        end
        // asynchronous assertion between edges, with a taken branch loaded
        drive(2'b01, 32'h00000063, 1'b1, 1'b0, 1'b0);
        tick();
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.ALUCtrl, bus.branch_taken} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_async: got %b/%b want 0000/0", bus.ALUCtrl, bus.branch_taken);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_branch();
        logic [31:0] ins [7];
        logic [3:0]  ec;
        logic        et;
        ins = '{32'h00000063, 32'h00001063, 32'h00004063, 32'h00005063,
                32'h00006063, 32'h00007063, 32'h00002063};
        for (int i = 0; i < 7; i++) begin
            for (int f = 0; f < 8; f++) begin
                drive(2'b01, ins[i], f[0], f[1], f[2]);
                model(2'b01, ins[i], f[0], f[1], f[2], ec, et);
                tick();
                n_checks++;
                if ({bus.ALUCtrl, bus.branch_taken} !== {ec, et}) begin
                    n_fail++;
                    $display("FAIL branch ins=%h flags=%b: got %b/%b want %b/%b",
                             ins[i], f[2:0], bus.ALUCtrl, bus.branch_taken, ec, et);
                end
            end
        end
    endtask

    task automatic test_arith();
        logic [31:0] ins [24];
        logic [3:0]  want [24];
        ins  = '{32'h00000033, 32'h40000033, 32'h00007033, 32'h00006033,
                 32'h00004033, 32'h00001033, 32'h00005033, 32'h40005033,
                 32'h00002033, 32'h00003033, 32'h02000033, 32'h02003033,
                 32'h00000013, 32'h40000013, 32'h00007013, 32'h00006013,
                 32'h00004013, 32'h00002013, 32'h00003013, 32'h00001013,
                 32'h00005013, 32'h40005013, 32'hFFFFFFFF, 32'h02004033};
        want = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101,
                 4'b0110, 4'b0111, 4'b1000, 4'b1001, 4'b1010, 4'b1101,
                 4'b0000, 4'b0000, 4'b0010, 4'b0011, 4'b0100, 4'b1000,
                 4'b1001, 4'b0101, 4'b0110, 4'b0111, 4'b0000, 4'b0000};
        for (int i = 0; i < 24; i++) begin
            drive(2'b10, ins[i], 1'b1, 1'b1, 1'b1);
            tick();
            n_checks++;
            if ({bus.ALUCtrl, bus.branch_taken} !== {want[i], 1'b0}) begin
                n_fail++;
                $display("FAIL arith ins=%h: got %b/%b want %b/0",
                         ins[i], bus.ALUCtrl, bus.branch_taken, want[i]);
            end
        end
    endtask

    task automatic test_defaults();
        logic [31:0] ins;
        for (int i = 0; i < 8; i++) begin
            ins = $urandom;
            drive((i % 2 == 0) ? 2'b00 : 2'b11, ins, 1'b1, 1'b1, 1'b1);
            tick();
            n_checks++;
            if ({bus.ALUCtrl, bus.branch_taken} !== 5'b0) begin
                n_fail++;
                $display("FAIL default op=%b ins=%h: got %b/%b want 0000/0",
                         bus.ALUOp, ins, bus.ALUCtrl, bus.branch_taken);
            end
        end
    endtask

    task automatic test_latency();
        drive(2'b10, 32'h00004033, 1'b0, 1'b0, 1'b0);
        tick();
        drive(2'b10, 32'h40005033, 1'b0, 1'b0, 1'b0);
        #2;
        n_checks++;
        if (bus.ALUCtrl !== 4'b0100) begin
            n_fail++;
            $display("FAIL latency_hold: got %b want 0100", bus.ALUCtrl);
        end
        drive(2'b01, 32'h00000063, 1'b1, 1'b0, 1'b0);
        #1;
        n_checks++;
        if ({bus.ALUCtrl, bus.branch_taken} !== 5'b01000) begin
            n_fail++;
            $display("FAIL latency_flag_hold: got %b/%b want 0100/0", bus.ALUCtrl, bus.branch_taken);
        end
        tick();
        n_checks++;
        if ({bus.ALUCtrl, bus.branch_taken} !== 5'b00011) begin
            n_fail++;
            $display("FAIL latency_update: got %b/%b want 0001/1", bus.ALUCtrl, bus.branch_taken);
        end
    endtask

    task automatic test_random();
        logic [6:0]  f7s [4];
        logic [31:0] ins;
        logic [1:0]  op;
        logic [2:0]  fl;
        logic [3:0]  ec;
        logic        et;
        f7s = '{7'h00, 7'h20, 7'h01, 7'h00};
        for (int i = 0; i < 400; i++) begin
            ins = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                f7s[3] = 7'($urandom);
                ins[31:25] = f7s[$urandom_range(0, 3)];
            end
            op = 2'($urandom_range(0, 3));
            fl = 3'($urandom);
            drive(op, ins, fl[0], fl[1], fl[2]);
            model(op, ins, fl[0], fl[1], fl[2], ec, et);
            tick();
            n_checks++;
            if ({bus.ALUCtrl, bus.branch_taken} !== {ec, et}) begin
                n_fail++;
                $display("FAIL random op=%b ins=%h flags=%b: got %b/%b want %b/%b",
                         op, ins, fl, bus.ALUCtrl, bus.branch_taken, ec, et);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        drive(2'b00, 32'h0, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_branch();
        test_arith();
        test_defaults();
        test_latency();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
